bbox_update_ctrl: RTL
=====================

// Module: bbox_update_ctrl
// PURPOSE
//  Sequences bounding-box updates from the object tracker into the video overlay.
//  Buffers one tracker result via valid/ready and commits it only at end of frame (v_sync fall),
//  so the drawn box never tears mid-frame. Validates and clamps coordinates.
//  Hides the box after HOLD_FRAMES consecutive frames without a detection.
// PARAMETERS
//  H_ACTIVE     640  active pixels per line; x clamp limit H_ACTIVE-1
//  V_ACTIVE     480  active lines per frame; y clamp limit V_ACTIVE-1
//  HOLD_FRAMES  8    missed frames tolerated before box hidden (1..255)
//  OFF_COORD    16'hFFFF  coordinate driven on all bbox outputs while hidden (never matches a pixel)
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  v_sync       in   1   high during active frame, low during vertical blanking
//  det_valid    in   1   tracker result valid
//  det_ready    out  1   controller can accept a result this cycle
//  det_found    in   1   1 = object present in result, 0 = explicit miss
//  det_x_min    in   16  tracker box left
//  det_x_max    in   16  tracker box right
//  det_y_min    in   16  tracker box top
//  det_y_max    in   16  tracker box bottom
//  bbox_x_min   out  16  committed box left, to overlay
//  bbox_x_max   out  16  committed box right
//  bbox_y_min   out  16  committed box top
//  bbox_y_max   out  16  committed box bottom
//  box_visible  out  1   1 = committed box being drawn
//  miss_cnt     out  8   consecutive frames without valid detection (saturates at 255)
//  reject_pulse out  1   one-cycle pulse when accepted result fails validation
// BEHAVIOUR
//  Reset: state=IDLE, pend empty, bbox_* = OFF_COORD, box_visible=0, miss_cnt=0, reject_pulse=0.
//  det_ready = ~pend_full | (state==COMMIT) (combinational); handshake = det_valid & det_ready.
//  On handshake: validation is min<=max on both axes with found=1; x_max clamped to H_ACTIVE-1,
//   y_max to V_ACTIVE-1; x_min>=H_ACTIVE or y_min>=V_ACTIVE also fails. Failing result:
//   reject_pulse=1 next cycle, stored as found=0. Newer result overwrites nothing: pend holds one.
//  v_sync registered once (vs_q); frame_end = vs_q & ~v_sync; frame_start = ~vs_q & v_sync.
//  FSM: IDLE --frame_start--> ACTIVE --frame_end--> COMMIT (1 cycle) --> BLANK --frame_start--> ACTIVE.
//   IDLE ignores frame_end (no partial first frame committed); handshakes still accepted in IDLE.
//  COMMIT, pend_full & found: bbox_* <= pend coords, box_visible<=1, miss_cnt<=0, pend emptied.
//  COMMIT, pend empty or found=0: miss_cnt<=sat(miss_cnt+1), pend emptied; if new miss_cnt>=HOLD_FRAMES:
//   box_visible<=0 and bbox_* <= OFF_COORD; else bbox_* hold.
//  Handshake in COMMIT cycle: COMMIT consumes old pend first, then new result loads pend (next frame).
//  Outputs change only on the COMMIT cycle (bbox_*, box_visible, miss_cnt); latency frame_end->update = 2 clk.
//  v_sync glitch (fall then rise before COMMIT ends) still completes COMMIT, then ACTIVE.
//  rst_n assertion at any time returns all state/outputs to reset values immediately.
// TESTING
//  1 Reset, frame with det (10,50,20,60,found) mid-frame -> bbox unchanged until frame_end;
//    2 clk after v_sync fall bbox=(10,50,20,60), box_visible=1, miss_cnt=0.
//  2 det_x_max=700 -> committed bbox_x_max=639; det x_min=100,x_max=90 -> reject_pulse, counted as miss.
//  3 Hold box then 8 frames with no det -> miss_cnt 1..8; after 8th COMMIT box_visible=0, bbox=FFFF.
//  4 Two back-to-back det_valid in one frame -> first accepted, det_ready=0 for second until COMMIT;
//    second presented in COMMIT cycle is accepted and committed next frame.
//  5 rst_n low mid-ACTIVE with pend full -> outputs to reset values, pend empty, next frame_end ignored (IDLE).
//  6 Detection at frame_end of very first (partial) frame after reset -> not committed; commits next frame_end.

Source files
------------

// File: rtl/bbox_update_ctrl.sv
// Bounding-box update controller: buffers one tracker result and commits it to
// the overlay only at end of frame, so the drawn box never tears mid-frame.
module bbox_update_ctrl #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          HOLD_FRAMES = 8,
    parameter logic [15:0] OFF_COORD   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v_sync,
    input  logic        det_valid,
    output logic        det_ready,
    input  logic        det_found,
    input  logic [15:0] det_x_min,
    input  logic [15:0] det_x_max,
    input  logic [15:0] det_y_min,
    input  logic [15:0] det_y_max,
    output logic [15:0] bbox_x_min,
    output logic [15:0] bbox_x_max,
    output logic [15:0] bbox_y_min,
    output logic [15:0] bbox_y_max,
    output logic        box_visible,
    output logic [7:0]  miss_cnt,
    output logic        reject_pulse
);

    localparam logic [15:0] X_LIM = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LIM = 16'(V_ACTIVE - 1);
    localparam logic [7:0]  HOLD  = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT, BLANK} state_t;

    state_t      state, state_nxt;
    logic        vs_q;
    logic        frame_end, frame_start;
    logic        handshake, det_ok, commit;
    logic        pend_full, pend_found;
    logic [15:0] pend_x_min, pend_x_max, pend_y_min, pend_y_max;
    logic [7:0]  miss_inc;

    assign frame_end   = vs_q & ~v_sync;
    assign frame_start = ~vs_q & v_sync;
    assign commit      = (state == COMMIT);
    assign det_ready   = ~pend_full | commit;
    assign handshake   = det_valid & det_ready;

    // Reject inverted or fully off-screen boxes and explicit misses.
    assign det_ok = det_found && (det_x_min <= det_x_max) && (det_y_min <= det_y_max)
                    && (det_x_min <= X_LIM) && (det_y_min <= Y_LIM);

    assign miss_inc = (miss_cnt == 8'hFF) ? 8'hFF : miss_cnt + 8'd1;

    // v_sync edge detector; resets high so a frame already in progress when
    // reset releases is not mistaken for a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vs_q <= 1'b1;
        else        vs_q <= v_sync;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; IDLE waits for a full frame before any commit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = ACTIVE;
            ACTIVE:  if (frame_end)   state_nxt = COMMIT;
            COMMIT:  state_nxt = frame_start ? ACTIVE : BLANK;
            BLANK:   if (frame_start) state_nxt = ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pending slot: COMMIT drains the old entry, a same-cycle handshake refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full    <= 1'b0;
            pend_found   <= 1'b0;
            pend_x_min   <= '0;
            pend_x_max   <= '0;
            pend_y_min   <= '0;
            pend_y_max   <= '0;
            reject_pulse <= 1'b0;
        end else begin
            reject_pulse <= handshake & ~det_ok;
            if (handshake) begin
                pend_full  <= 1'b1;
                pend_found <= det_ok;
                pend_x_min <= det_x_min;
                pend_x_max <= (det_x_max > X_LIM) ? X_LIM : det_x_max;
                pend_y_min <= det_y_min;
                pend_y_max <= (det_y_max > Y_LIM) ? Y_LIM : det_y_max;
            end else if (commit) begin
                pend_full  <= 1'b0;
            end
        end
    end

    // Overlay outputs update only in the COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bbox_x_min  <= OFF_COORD;
            bbox_x_max  <= OFF_COORD;
            bbox_y_min  <= OFF_COORD;
            bbox_y_max  <= OFF_COORD;
            box_visible <= 1'b0;
            miss_cnt    <= '0;
        end else if (commit) begin
            if (pend_full && pend_found) begin
                bbox_x_min  <= pend_x_min;
                bbox_x_max  <= pend_x_max;
                bbox_y_min  <= pend_y_min;
                bbox_y_max  <= pend_y_max;
                box_visible <= 1'b1;
                miss_cnt    <= '0;
            end else begin
                miss_cnt <= miss_inc;
                if (miss_inc >= HOLD) begin
                    bbox_x_min  <= OFF_COORD;
                    bbox_x_max  <= OFF_COORD;
                    bbox_y_min  <= OFF_COORD;
                    bbox_y_max  <= OFF_COORD;
                    box_visible <= 1'b0;
                end
            end
        end
    end

endmodule
